// File: rtl/turfio_ps_ctrl.sv
// turfio_ps_ctrl
//   Drives the fine phase-shift port of an MMCM. A request asks for N
//   increment steps; each step is one PSEN pulse followed by a wait for
//   PSDONE. The accumulated phase is tracked modulo PHASE_WRAP, which is the
//   number of fine steps in one RXCLK period.
//
//   Optional build macro: TURFIO_PS_TIMEOUT_EN
//     When defined, a step that waits PS_TIMEOUT clocks without PSDONE is
//     abandoned. The request ends and err_o is set.
//
// Ports
//   clk_i         phase-shift clock (MMCM PSCLK), the only clock
//   rst_n_i       synchronous active-low reset
//   locked_i      MMCM LOCKED (asynchronous, synchronized here)
//   step_valid_i  request to apply step_count_i increments
//   step_count_i  number of increments, sampled on acceptance
//   step_ready_o  idle with a valid lock; accept = valid & ready
//   ps_en_o       MMCM PSEN, single-cycle pulse
//   ps_done_i     MMCM PSDONE
//   phase_o       accumulated phase, 0..PHASE_WRAP-1
//   busy_o        request in progress
//   err_o         sticky error (timeout or lock loss mid-request)
//   err_clr_i     clears err_o; a simultaneous new error wins
module turfio_ps_ctrl #(
  parameter int PHASE_WRAP = 672,
  parameter int PS_TIMEOUT = 63
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        locked_i,
  input  logic        step_valid_i,
  input  logic [15:0] step_count_i,
  output logic        step_ready_o,
  output logic        ps_en_o,
  input  logic        ps_done_i,
  output logic [9:0]  phase_o,
  output logic        busy_o,
  output logic        err_o,
  input  logic        err_clr_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Two-stage synchronizer for the asynchronous LOCKED input.
  (* ASYNC_REG = "TRUE" *) logic lock_meta_q;
  (* ASYNC_REG = "TRUE" *) logic lock_sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      lock_meta_q <= locked_i;
      lock_sync_q <= lock_meta_q;
    end
  end

  state_t      state_q;
  logic [15:0] remaining_q;
  logic [9:0]  phase_q;
  logic        ps_en_q;
  logic        busy_q;
  logic        err_q;
  logic        err_set;
  logic        timeout_hit;

`ifdef TURFIO_PS_TIMEOUT_EN
  localparam int TW = $clog2(PS_TIMEOUT + 1);
  logic [TW-1:0] to_cnt_q;

  // The counter holds k during the (k+1)-th WAIT cycle. Expiry is declared
  // at the end of the PS_TIMEOUT-th WAIT cycle.
  assign timeout_hit = (state_q == WAIT) && !ps_done_i &&
                       (to_cnt_q == TW'(PS_TIMEOUT - 1));
`else
  logic unused_timeout_param;
  assign unused_timeout_param = (PS_TIMEOUT != 0);
  assign timeout_hit = 1'b0;
`endif

  // Losing lock aborts a request in flight. Losing lock in IDLE is not an error.
  assign err_set = (!lock_sync_q && (state_q != IDLE)) ||
                   (lock_sync_q && timeout_hit);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      remaining_q <= 16'd0;
      phase_q     <= 10'd0;
      ps_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef TURFIO_PS_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      ps_en_q <= 1'b0;

      if (err_set) begin
        err_q <= 1'b1;
      end else if (err_clr_i) begin
        err_q <= 1'b0;
      end

      if (!lock_sync_q) begin
        state_q     <= IDLE;
        remaining_q <= 16'd0;
        phase_q     <= 10'd0;
        busy_q      <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (step_valid_i) begin
              remaining_q <= step_count_i;
              if (step_count_i != 16'd0) begin
                state_q <= ISSUE;
                ps_en_q <= 1'b1;
                busy_q  <= 1'b1;
              end
            end
          end

          ISSUE: begin
            state_q <= WAIT;
`ifdef TURFIO_PS_TIMEOUT_EN
            to_cnt_q <= '0;
`endif
          end

          WAIT: begin
            if (ps_done_i) begin
              if (phase_q == 10'(PHASE_WRAP - 1)) begin
                phase_q <= 10'd0;
              end else begin
                phase_q <= phase_q + 10'd1;
              end
              remaining_q <= remaining_q - 16'd1;
              if (remaining_q == 16'd1) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q <= ISSUE;
                ps_en_q <= 1'b1;
              end
            end else if (timeout_hit) begin
              remaining_q <= 16'd0;
              state_q     <= IDLE;
              busy_q      <= 1'b0;
            end
`ifdef TURFIO_PS_TIMEOUT_EN
            else begin
              to_cnt_q <= to_cnt_q + TW'(1);
            end
`endif
          end

          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign step_ready_o = (state_q == IDLE) && lock_sync_q;
  assign ps_en_o      = ps_en_q;
  assign busy_o       = busy_q;
  assign phase_o      = phase_q;
  assign err_o        = err_q;

endmodule
